systolic_array_line_buffer: RTL

//  Upstream feeder for the 3x3 gradient kernel cells (Scharr X/Y).
//  - Takes a raster pixel stream and buffers the two previous image rows.
//  - Emits three vertically aligned pixels per column (x1 = row r-2, x2 = row r-1, x3 = row r).
//  - Pulses new_row so each kernel cell's control can flush between rows.

---
 rtl/systolic_array_pkg.sv | 17 +
 rtl/systolic_array_line_buffer_if.sv | 26 ++
 rtl/systolic_array_line_ram.sv | 22 ++
 rtl/systolic_array_line_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared types and constants for the systolic-array line buffer.
package systolic_array_pkg;

    typedef enum logic [1:0] {LB_FILL0, LB_FILL1, LB_STREAM, LB_GAP} lb_state_t;

    localparam int unsigned LB_GAP_CYCLES = 2;
    localparam int unsigned LB_GAP_CNT_W  = 2;

    // Row state that follows a completed row.
    function automatic lb_state_t lb_next_row(input lb_state_t s);
        case (s)
            LB_FILL0: lb_next_row = LB_FILL1;
            default:  lb_next_row = LB_STREAM;
        endcase
    endfunction

endpackage

// File: rtl/systolic_array_line_buffer_if.sv
// Pixel-in stream and three-tap column output bundle of the line buffer.
interface systolic_array_line_buffer_if #(
    parameter int unsigned data_width = 8
);
    logic [data_width-1:0] pix_in;
    logic                  pix_in_val;
    logic                  pix_in_sof;
    logic                  pix_in_rdy;
    logic [data_width-1:0] x1;
    logic                  x1_val;
    logic [data_width-1:0] x2;
    logic                  x2_val;
    logic [data_width-1:0] x3;
    logic                  x3_val;
    logic                  new_row;

    modport slave (
        input  pix_in, pix_in_val, pix_in_sof,
        output pix_in_rdy, x1, x1_val, x2, x2_val, x3, x3_val, new_row
    );

    modport master (
        output pix_in, pix_in_val, pix_in_sof,
        input  pix_in_rdy, x1, x1_val, x2, x2_val, x3, x3_val, new_row
    );
endinterface

// File: rtl/systolic_array_line_ram.sv
// One-row pixel store: single write port, asynchronous read (old data on same-address write).
module systolic_array_line_ram #(
    parameter int unsigned data_width = 8,
    parameter int unsigned img_width  = 640
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(img_width)-1:0]  i_waddr,
    input  logic [data_width-1:0]         i_wdata,
    input  logic [$clog2(img_width)-1:0]  i_raddr,
    output logic [data_width-1:0]         o_rdata
);
    logic [data_width-1:0] r_mem [img_width];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/systolic_array_line_buffer.sv
// Two-row line buffer feeding 3x3 gradient cells with vertically aligned pixel triples.
// Optional top-border replication: define SYSTOLIC_LINE_BUFFER_EDGE_REPLICATE_EN.
module systolic_array_line_buffer
    import systolic_array_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned img_width  = 640
) (
    input  logic                         clk,
    input  logic                         reset,
    systolic_array_line_buffer_if.slave  bus
);
    localparam int unsigned col_bits = $clog2(img_width);
    localparam logic [col_bits-1:0] LAST_COL = col_bits'(img_width - 1);
    localparam logic [LB_GAP_CNT_W-1:0] GAP_LAST = LB_GAP_CNT_W'(LB_GAP_CYCLES - 1);

    lb_state_t                 r_state, w_state_nxt;
    lb_state_t                 r_row_state, w_row_state_nxt;
    logic [col_bits-1:0]       r_col, w_col_nxt;
    logic [LB_GAP_CNT_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic                      r_rdy, w_rdy_nxt;
    logic [data_width-1:0]     r_x1, r_x2, r_x3, w_x1_nxt, w_x2_nxt, w_x3_nxt;
    logic                      r_val, w_val_nxt;
    logic                      r_new_row, w_new_row_nxt;

    logic                      w_accept;
    logic [col_bits-1:0]       w_addr;
    logic [data_width-1:0]     w_a_rd, w_b_rd;
    lb_state_t                 w_emit_state;

    assign w_accept     = bus.pix_in_val & r_rdy;
    // A start-of-frame pixel always lands at column 0 of a fresh row 0.
    assign w_addr       = bus.pix_in_sof ? '0 : r_col;
    assign w_emit_state = bus.pix_in_sof ? LB_FILL0 : r_state;

    systolic_array_line_ram #(.data_width(data_width), .img_width(img_width)) u_ram_a (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_addr),
        .i_wdata (bus.pix_in),
        .i_raddr (w_addr),
        .o_rdata (w_a_rd)
    );

    systolic_array_line_ram #(.data_width(data_width), .img_width(img_width)) u_ram_b (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_addr),
        .i_wdata (w_a_rd),
        .i_raddr (w_addr),
        .o_rdata (w_b_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LB_FILL0;
            r_row_state <= LB_FILL0;
            r_col       <= '0;
            r_gap_cnt   <= '0;
            r_rdy       <= 1'b1;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_val       <= 1'b0;
            r_new_row   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_state <= w_row_state_nxt;
            r_col       <= w_col_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_rdy       <= w_rdy_nxt;
            r_x1        <= w_x1_nxt;
            r_x2        <= w_x2_nxt;
            r_x3        <= w_x3_nxt;
            r_val       <= w_val_nxt;
            r_new_row   <= w_new_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_row_state_nxt = r_row_state;
        w_col_nxt       = r_col;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_rdy_nxt       = r_rdy;
        w_x1_nxt        = r_x1;
        w_x2_nxt        = r_x2;
        w_x3_nxt        = r_x3;
        w_val_nxt       = 1'b0;
        w_new_row_nxt   = 1'b0;

        if (r_state == LB_GAP) begin
            if (r_gap_cnt == GAP_LAST) begin
                w_state_nxt   = r_row_state;
                w_gap_cnt_nxt = '0;
                w_rdy_nxt     = 1'b1;
            end else begin
                w_gap_cnt_nxt = r_gap_cnt + LB_GAP_CNT_W'(1);
            end
        end else if (w_accept) begin
            // Output tap selection for the row this pixel belongs to.
            case (w_emit_state)
                LB_STREAM: begin
                    w_x1_nxt  = w_b_rd;
                    w_x2_nxt  = w_a_rd;
                    w_x3_nxt  = bus.pix_in;
                    w_val_nxt = 1'b1;
                end
`ifdef SYSTOLIC_LINE_BUFFER_EDGE_REPLICATE_EN
                LB_FILL0: begin
                    w_x1_nxt  = bus.pix_in;
                    w_x2_nxt  = bus.pix_in;
                    w_x3_nxt  = bus.pix_in;
                    w_val_nxt = 1'b1;
                end
                LB_FILL1: begin
                    w_x1_nxt  = w_a_rd;
                    w_x2_nxt  = w_a_rd;
                    w_x3_nxt  = bus.pix_in;
                    w_val_nxt = 1'b1;
                end
`endif
                default: ;
            endcase

            if (bus.pix_in_sof) begin
                w_col_nxt     = col_bits'(1);
                w_state_nxt   = LB_FILL0;
                w_new_row_nxt = (r_state == LB_STREAM);
            end else if (r_col == LAST_COL) begin
                w_col_nxt       = '0;
                w_state_nxt     = LB_GAP;
                w_row_state_nxt = lb_next_row(r_state);
                w_gap_cnt_nxt   = '0;
                w_rdy_nxt       = 1'b0;
`ifdef SYSTOLIC_LINE_BUFFER_EDGE_REPLICATE_EN
                w_new_row_nxt   = 1'b1;
`else
                w_new_row_nxt   = (r_state == LB_STREAM);
`endif
            end else begin
                w_col_nxt = r_col + col_bits'(1);
            end
        end
    end

    assign bus.pix_in_rdy = r_rdy;
    assign bus.x1         = r_x1;
    assign bus.x2         = r_x2;
    assign bus.x3         = r_x3;
    assign bus.x1_val     = r_val;
    assign bus.x2_val     = r_val;
    assign bus.x3_val     = r_val;
    assign bus.new_row    = r_new_row;
endmodule
